pll_lock_ctrl: RTL and testbench

- Sequences start-up and recovery of the iCE40 PLL that turns the 16 MHz board clock into the 50 MHz system clock.
- Runs on the free-running 16 MHz reference clock, not the PLL output, so it keeps working while the PLL is unlocked.
- Drives the PLL RESETB and synchronises the asynchronous LOCK output.
- Qualifies lock stability, retries on lock timeout, and produces the system reset, ready and fail status for the rest of the design.

---
 rtl/pll_lock_ctrl.sv | 153 +++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl.sv
// iCE40 PLL start-up/recovery sequencer on the free-running reference clock:
// drives RESETB, qualifies LOCK, retries on timeout and issues system reset/status.
module pll_lock_ctrl #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int LOCK_STABLE    = 256,
  parameter int MAX_RETRY      = 7,
  parameter int RETRY_W        = 4
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               pll_lock,
  input  logic               soft_restart,
  output logic               pll_resetb,
  output logic               sys_reset,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_count,
  output logic [7:0]         lock_loss_count
);

  localparam int TMAX0 = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int TMAX  = (TMAX0 > LOCK_STABLE) ? TMAX0 : LOCK_STABLE;
  localparam int TW    = $clog2(TMAX);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [7:0]         llc_q, llc_d;
  logic               lock_meta_q, lock_s_q;
  logic               pll_resetb_q, pll_resetb_d;
  logic               sys_reset_q, sys_reset_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;

  // Two-flop synchroniser for the asynchronous LOCK output.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= PLL_RST;
      timer_q      <= '0;
      retry_q      <= '0;
      llc_q        <= '0;
      pll_resetb_q <= 1'b0;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      llc_q        <= llc_d;
      pll_resetb_q <= pll_resetb_d;
      sys_reset_q  <= sys_reset_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    llc_d   = llc_q;
    case (state_q)
      PLL_RST: begin
        if (timer_q == TW'(PLL_RST_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = STABLE;
          timer_d = '0;
        end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
          timer_d = '0;
          if (retry_q == RETRY_W'(MAX_RETRY)) begin
            state_d = FAIL;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = PLL_RST;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STABLE: begin
        // A dropout restarts the full lock wait without costing a retry.
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == TW'(LOCK_STABLE - 1)) begin
          state_d = RUN;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s_q) begin
          if (llc_q != 8'hFF) llc_d = llc_q + 1'b1;
          state_d = PLL_RST;
          timer_d = '0;
        end
      end
      FAIL: begin
        timer_d = '0;
      end
      default: begin
        state_d = PLL_RST;
        timer_d = '0;
      end
    endcase
    // Soft restart overrides the transition but keeps any lock-loss count taken above.
    if (soft_restart) begin
      state_d = PLL_RST;
      timer_d = '0;
      retry_d = '0;
    end
    pll_resetb_d = !((state_d == PLL_RST) || (state_d == FAIL));
    sys_reset_d  = (state_d != RUN);
    ready_d      = (state_d == RUN);
    fail_d       = (state_d == FAIL);
  end

  assign pll_resetb      = pll_resetb_q;
  assign sys_reset       = sys_reset_q;
  assign ready           = ready_q;
  assign fail            = fail_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = llc_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with small parameters and hand-computed timing.
module tb_pll_lock_ctrl;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       soft_restart = 1'b0;
  logic       pll_resetb, sys_reset, ready, fail;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  int tests = 0;
  int fails = 0;

  pll_lock_ctrl #(
    .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(32), .LOCK_STABLE(8), .MAX_RETRY(2), .RETRY_W(4)
  ) dut (
    .clk_in(clk_in), .reset(reset), .pll_lock(pll_lock), .soft_restart(soft_restart),
    .pll_resetb(pll_resetb), .sys_reset(sys_reset), .ready(ready), .fail(fail),
    .retry_count(retry_count), .lock_loss_count(lock_loss_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".pll_resetb"}, 32'(pll_resetb), 0);
    check({tag, ".sys_reset"}, 32'(sys_reset), 1);
    check({tag, ".ready"}, 32'(ready), 0);
    check({tag, ".fail"}, 32'(fail), 0);
    check({tag, ".retry"}, 32'(retry_count), 0);
    check({tag, ".llc"}, 32'(lock_loss_count), 0);
  endtask

  // Starts just after PLL_RST was entered with timer 0; ends in RUN.
  task automatic bringup(input string tag);
    pll_lock = 1'b0;
    repeat (3) tick();
    check({tag, ".resetb_low"}, 32'(pll_resetb), 0);
    tick();
    check({tag, ".resetb_high"}, 32'(pll_resetb), 1);
    repeat (10) tick();
    pll_lock = 1'b1;
    repeat (10) tick();
    check({tag, ".sysrst_edge10"}, 32'(sys_reset), 1);
    check({tag, ".ready_edge10"}, 32'(ready), 0);
    tick();
    check({tag, ".sysrst_edge11"}, 32'(sys_reset), 0);
    check({tag, ".ready_edge11"}, 32'(ready), 1);
    check({tag, ".retry"}, 32'(retry_count), 0);
  endtask

  initial begin
    // 1: reset values and normal bring-up
    repeat (3) tick();
    check_reset_vals("s1.rst");
    reset = 1'b0;
    bringup("s1");

    // 2: lock dropout in STABLE at timer=5
    reset = 1'b1;
    pll_lock = 1'b0;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    check("s2.resetb_high", 32'(pll_resetb), 1);
    pll_lock = 1'b1;
    repeat (8) tick();
    pll_lock = 1'b0;
    repeat (2) tick();
    pll_lock = 1'b1;
    repeat (10) tick();
    check("s2.ready_late", 32'(ready), 0);
    check("s2.sysrst_late", 32'(sys_reset), 1);
    tick();
    check("s2.ready", 32'(ready), 1);
    check("s2.retry", 32'(retry_count), 0);

    // 3: timeouts to failure
    reset = 1'b1;
    pll_lock = 1'b0;
    tick();
    reset = 1'b0;
    repeat (35) tick();
    check("s3.wait1_resetb", 32'(pll_resetb), 1);
    check("s3.wait1_retry", 32'(retry_count), 0);
    tick();
    check("s3.to1_resetb", 32'(pll_resetb), 0);
    check("s3.to1_retry", 32'(retry_count), 1);
    repeat (4) tick();
    check("s3.wait2_resetb", 32'(pll_resetb), 1);
    repeat (31) tick();
    check("s3.wait2_retry", 32'(retry_count), 1);
    tick();
    check("s3.to2_resetb", 32'(pll_resetb), 0);
    check("s3.to2_retry", 32'(retry_count), 2);
    repeat (4) tick();
    check("s3.wait3_resetb", 32'(pll_resetb), 1);
    repeat (31) tick();
    check("s3.wait3_fail", 32'(fail), 0);
    tick();
    check("s3.fail", 32'(fail), 1);
    check("s3.fail_resetb", 32'(pll_resetb), 0);
    check("s3.fail_sysrst", 32'(sys_reset), 1);
    check("s3.fail_retry", 32'(retry_count), 2);
    repeat (100) tick();
    check("s3.fail_hold", 32'(fail), 1);
    check("s3.fail_hold_resetb", 32'(pll_resetb), 0);

    // 4: recovery from FAIL via soft_restart
    soft_restart = 1'b1;
    tick();
    soft_restart = 1'b0;
    check("s4.retry", 32'(retry_count), 0);
    check("s4.fail", 32'(fail), 0);
    check("s4.resetb", 32'(pll_resetb), 0);
    bringup("s4");

    // 5: repeated lock loss in RUN, counter saturates
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      repeat (2) tick();
      check("s5.sysrst_edge2", 32'(sys_reset), 0);
      tick();
      check("s5.sysrst_edge3", 32'(sys_reset), 1);
      check("s5.resetb_edge3", 32'(pll_resetb), 0);
      check("s5.llc", 32'(lock_loss_count), (i + 1 > 255) ? 255 : i + 1);
      pll_lock = 1'b1;
      repeat (12) tick();
      check("s5.relock_early", 32'(ready), 0);
      tick();
      check("s5.relock", 32'(ready), 1);
    end
    check("s5.retry", 32'(retry_count), 0);

    // 6a: async reset between edges in RUN
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals("s6a.async");
    tick();
    reset = 1'b0;
    bringup("s6a");

    // 6b: soft_restart on the same edge as a RUN lock loss
    pll_lock = 1'b0;
    repeat (2) tick();
    soft_restart = 1'b1;
    tick();
    soft_restart = 1'b0;
    check("s6b.resetb", 32'(pll_resetb), 0);
    check("s6b.sysrst", 32'(sys_reset), 1);
    check("s6b.llc", 32'(lock_loss_count), 1);
    check("s6b.retry", 32'(retry_count), 0);
    repeat (3) tick();
    check("s6b.resetb_hold", 32'(pll_resetb), 0);
    tick();
    check("s6b.resetb_rel", 32'(pll_resetb), 1);
    check("s6b.llc_after", 32'(lock_loss_count), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
